keccak_absorb: RTL
==================

// Module: keccak_absorb
// PURPOSE
//  Sponge absorb/padding stage directly upstream of keccakf1600lanes. Accepts a message as
//  64-bit words over a valid/ready handshake, XORs them into the rate part of the 1600-bit
//  state, applies SHA3/SHAKE padding, and hands the state to keccakf1600lanes for each full block.
//  Emits the absorbed state (after the final permutation) to the downstream squeeze stage.
// PARAMETERS
//  BW_DATA   1600  state width (25 lanes x 64 bits)
//  BW_WORD   64    message word / lane width
// PORTS
//  i_clk          in   1     clock
//  i_rst          in   1     reset, asynchronous, active-high
//  i_start        in   1     begin a new hash; honoured in IDLE only
//  i_rate         in   5     rate in lanes (SHA3-512 9, SHA3-256/SHAKE256 17, SHAKE128 21), sampled on i_start
//  i_dsep         in   8     domain-separation byte (SHA3 0x06, SHAKE 0x1F), sampled on i_start
//  i_data         in   64    message word, byte j at bits [8j+7:8j]
//  i_bytes        in   4     valid bytes in i_data: 8 for non-last beats, 0..7 on the last beat
//  i_last         in   1     final beat of the message
//  i_valid        in   1     message beat valid
//  o_ready        out  1     stage accepts a beat this cycle
//  o_perm_lane    out  1600  state driven to keccakf1600lanes i_lane (lane k = bits [64k+63:64k], k=x+5y)
//  o_perm_start   out  1     one-cycle request to start a permutation
//  i_perm_lane    in   1600  permuted state from keccakf1600lanes o_lane
//  i_perm_valid   in   1     permuted state valid (keccakf1600lanes o_valid)
//  o_state        out  1600  absorbed state to squeeze stage
//  o_state_valid  out  1     one-cycle pulse, o_state valid
// BEHAVIOUR
//  Reset: FSM=IDLE; state, lane_idx, final flag, o_perm_lane, o_state all 0; o_ready, o_perm_start, o_state_valid 0.
//  o_perm_lane is the internal state register; o_state is a copy loaded when absorb completes.
//  i_rate 0 or >21 is clamped to 21 when sampled.
//  FSM states: IDLE, ABSORB, PERM, DONE.
//  IDLE: o_ready=0. i_start -> state<=0, lane_idx<=0, final<=0, latch rate/dsep, go ABSORB (next cycle).
//  ABSORB: o_ready=1. Beat accepted when i_valid&o_ready:
//   - lane[lane_idx] ^= i_data with bytes >= i_bytes masked to zero.
//   - non-last: if lane_idx==rate-1 -> lane_idx<=0, go PERM (final=0); else lane_idx++.
//   - last: additionally XOR dsep into byte i_bytes of lane[lane_idx] and 0x80 into byte 7 of
//     lane[rate-1] (same cycle; both XOR if coincident, e.g. 0x86). final<=1, go PERM.
//   - message length multiple of 8 bytes ends with a last beat of i_bytes=0 (empty message = one such beat).
//   - i_bytes=8 with i_last, or i_bytes<8 without i_last: treated as i_bytes=7 / 8 respectively.
//  PERM: o_ready=0. o_perm_start=1 in the first PERM cycle only. Wait for i_perm_valid:
//   state<=i_perm_lane; final ? (o_state<=i_perm_lane, go DONE) : go ABSORB.
//   i_perm_valid same cycle as o_perm_start is accepted. i_perm_valid outside PERM ignored.
//  DONE: o_state_valid=1 for exactly one cycle, go IDLE. o_state holds until next DONE or reset.
//  i_start outside IDLE ignored. i_valid outside ABSORB not consumed (no beat lost/duplicated).
//  Latency: last beat accepted -> o_perm_start next cycle; i_perm_valid -> o_state_valid next cycle.
//  Reset mid-operation: immediate return to reset values; a late i_perm_valid afterwards is ignored.
// TESTING
//  1 SHAKE128 empty msg: start rate=21 dsep=0x1F, beat last bytes=0, echo stub -> o_perm_lane lane0=0x1F,
//    lane20=0x8000000000000000, rest 0; one o_perm_start; o_state equals it, o_state_valid one pulse.
//  2 SHA3-256 "abc": rate=17 dsep=0x06, data=0x636261 bytes=3 last -> lane0=0x06636261,
//    lane16=0x8000000000000000; with real keccakf1600lanes o_state lanes0..3 give digest 3a985da7...
//  3 Multi-block: rate=21, 21 full beats then last bytes=0 -> two o_perm_start, o_ready=0 during both
//    PERMs, second block XORed onto stub output of first.
//  4 Coincident pad: rate=9 dsep=0x06, 8 full beats, last beat bytes=7 -> lane8 byte7 = data^0x86.
//  5 Reset asserted in PERM -> all outputs 0, IDLE; later i_perm_valid produces no o_state_valid.
//  6 Backpressure: i_valid held high through PERM/DONE/IDLE, i_start ignored when busy -> beat count
//    consumed equals handshakes, state matches reference model.

Source files
------------

// File: rtl/keccak_absorb.sv
// Sponge absorb/padding stage for Keccak: XORs 64-bit message words into the rate lanes,
// applies SHA3/SHAKE padding on the last beat and sequences one permutation per block.
module keccak_absorb #(
  parameter int BW_DATA = 1600,
  parameter int BW_WORD = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [4:0]         i_rate,
  input  logic [7:0]         i_dsep,
  input  logic [BW_WORD-1:0] i_data,
  input  logic [3:0]         i_bytes,
  input  logic               i_last,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [BW_DATA-1:0] o_perm_lane,
  output logic               o_perm_start,
  input  logic [BW_DATA-1:0] i_perm_lane,
  input  logic               i_perm_valid,
  output logic [BW_DATA-1:0] o_state,
  output logic               o_state_valid
);

  localparam logic [4:0] RATE_MAX = 5'd21;

  typedef enum logic [1:0] {IDLE, ABSORB, PERM, DONE} fsm_t;

  fsm_t               fsm;
  logic [BW_DATA-1:0] st;
  logic [4:0]         lane_idx;
  logic [4:0]         rate;
  logic [7:0]         dsep;
  logic               final_blk;
  logic [BW_DATA-1:0] delta;
  logic [3:0]         nb;
  int                 word_lsb;
  int                 pad_bit;

  function automatic logic [4:0] clamp_rate(input logic [4:0] r);
    return (r == 5'd0 || r > RATE_MAX) ? RATE_MAX : r;
  endfunction

  // Full beats always carry 8 bytes; a last beat carries at most 7 so the
  // domain byte always fits into the same lane.
  function automatic logic [3:0] eff_bytes(input logic [3:0] b, input logic last);
    if (!last)
      return 4'd8;
    return (b > 4'd7) ? 4'd7 : b;
  endfunction

  function automatic logic [BW_WORD-1:0] absorb_word(input logic [BW_WORD-1:0] data,
                                                     input logic [3:0]         n,
                                                     input logic               last,
                                                     input logic [7:0]         ds);
    logic [BW_WORD-1:0] w;
    w = '0;
    for (int j = 0; j < BW_WORD / 8; j++)
      if (j < int'(n))
        w[8*j +: 8] = data[8*j +: 8];
    if (last)
      w[8*int'(n) +: 8] = ds;
    return w;
  endfunction

  always_comb begin
    nb       = eff_bytes(i_bytes, i_last);
    word_lsb = int'(lane_idx) * BW_WORD;
    pad_bit  = (int'(rate) - 1) * BW_WORD + BW_WORD - 1;
    delta    = '0;
    delta[word_lsb +: BW_WORD] = absorb_word(i_data, nb, i_last, dsep);
    // Final 0x80 pad bit; toggled so it merges with the domain byte when both land in one byte
    if (i_last)
      delta[pad_bit] = ~delta[pad_bit];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fsm           <= IDLE;
      st            <= '0;
      lane_idx      <= '0;
      rate          <= '0;
      dsep          <= '0;
      final_blk     <= 1'b0;
      o_state       <= '0;
      o_ready       <= 1'b0;
      o_perm_start  <= 1'b0;
      o_state_valid <= 1'b0;
    end else begin
      o_perm_start  <= 1'b0;
      o_state_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (i_start) begin
            st        <= '0;
            lane_idx  <= '0;
            final_blk <= 1'b0;
            rate      <= clamp_rate(i_rate);
            dsep      <= i_dsep;
            o_ready   <= 1'b1;
            fsm       <= ABSORB;
          end
        end
        ABSORB: begin
          if (i_valid && o_ready) begin
            st <= st ^ delta;
            if (i_last) begin
              final_blk    <= 1'b1;
              o_ready      <= 1'b0;
              o_perm_start <= 1'b1;
              fsm          <= PERM;
            end else if (lane_idx == rate - 5'd1) begin
              lane_idx     <= '0;
              final_blk    <= 1'b0;
              o_ready      <= 1'b0;
              o_perm_start <= 1'b1;
              fsm          <= PERM;
            end else begin
              lane_idx <= lane_idx + 5'd1;
            end
          end
        end
        PERM: begin
          if (i_perm_valid) begin
            st <= i_perm_lane;
            if (final_blk) begin
              o_state       <= i_perm_lane;
              o_state_valid <= 1'b1;
              fsm           <= DONE;
            end else begin
              o_ready <= 1'b1;
              fsm     <= ABSORB;
            end
          end
        end
        DONE: fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

  assign o_perm_lane = st;

endmodule
